cnn_layer_sequencer: RTL and testbench

//  Control initiator for one conv+relu+maxpool layer pass of top_module4; it drives the enable/clear fabric the datapath consumes.

---
 rtl/cnn_layer_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// Control initiator for one conv+relu+maxpool layer pass: drives the datapath clear/enable fabric.
// Optional watchdog on the w_done / maxpool_done waits is built when CNN_SEQ_TIMEOUT_EN is defined.
module cnn_layer_sequencer #(
  parameter int array_size     = 9,
  parameter int clear_cycles   = 4,
  parameter int drain_cycles   = 9,
  parameter int timeout_cycles = 1024
) (
  input  logic                  s_clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [15:0]           stream_len_i,
  input  logic                  w_done_i,
  input  logic                  maxpool_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  clear_n_o,
  output logic [array_size-1:0] relu_clear_o,
  output logic [array_size-1:0] buffer_fill_reset_o,
  output logic                  weight_write_enable_o,
  output logic [array_size-1:0] r_en_o,
  output logic [array_size-1:0] bias_enable_o,
  output logic [array_size-1:0] buffer_fill_enable_o,
  output logic [array_size-1:0] maxpool_arr_enable_o,
  output logic [array_size-1:0] maxpool_fill_enable_o,
  output logic [array_size-1:0] maxpool_arr_r_en_o
);

  // state | meaning
  // IDLE  | waiting for start; clears released, enables off
  // CLEAR | all datapath clears held low for clear_cycles
  // WLOAD | weight_write_enable high until w_done
  // FEED  | r_en thermometer ramp, then stream_len cycles full
  // BIAS  | bias_enable raised, one cycle
  // FILL  | buffer_fill_enable ramp, then drain_cycles full
  // POOL  | maxpool enables staged over 3 cycles, then wait maxpool_done
  // DONE  | enables off, one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WLOAD, S_FEED, S_BIAS, S_FILL, S_POOL, S_DONE
  } state_t;

  localparam int MAX_A   = array_size + 65535;
  localparam int MAX_B   = (drain_cycles > clear_cycles) ? drain_cycles : clear_cycles;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_ALL = (MAX_AB > timeout_cycles) ? MAX_AB : timeout_cycles;
  localparam int CW      = $clog2(MAX_ALL + 1);

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [15:0]             len_q;
  logic                    busy_q, done_q, clear_n_q, we_q;
  logic [array_size-1:0]   r_en_q, bias_q, bfe_q, mp_arr_q, mp_fill_q, mp_rd_q;
  logic                    accept_d, kill_d, wd_fire_d;
  logic [array_size-1:0]   ramp_d;

  function automatic logic [array_size-1:0] therm(input logic [CW-1:0] n);
    logic [array_size-1:0] t;
    t = '0;
    for (int i = 0; i < array_size; i++) begin
      if (CW'(i) < n) t[i] = 1'b1;
    end
    return t;
  endfunction

  assign accept_d = (state_q == S_IDLE) && start_i && !abort_i;
  assign kill_d   = ((state_q != S_IDLE) && abort_i) || wd_fire_d;
  assign ramp_d   = therm(cnt_q + CW'(2));

  always_ff @(posedge s_clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clear_n_q <= 1'b0;
      we_q      <= 1'b0;
      r_en_q    <= '0;
      bias_q    <= '0;
      bfe_q     <= '0;
      mp_arr_q  <= '0;
      mp_fill_q <= '0;
      mp_rd_q   <= '0;
    end else if (kill_d) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clear_n_q <= 1'b1;
      we_q      <= 1'b0;
      r_en_q    <= '0;
      bias_q    <= '0;
      bfe_q     <= '0;
      mp_arr_q  <= '0;
      mp_fill_q <= '0;
      mp_rd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          clear_n_q <= !accept_d;
          if (accept_d) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            len_q   <= stream_len_i;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (cnt_q == CW'(clear_cycles - 1)) begin
            state_q   <= S_WLOAD;
            cnt_q     <= '0;
            clear_n_q <= 1'b1;
            we_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WLOAD: begin
          if (w_done_i) begin
            state_q <= S_FEED;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            r_en_q  <= therm(CW'(1));
          end
        end
        S_FEED: begin
          // ramp is array_size cycles, then len_q cycles held full
          if (cnt_q == CW'(array_size - 1) + CW'(len_q)) begin
            state_q <= S_BIAS;
            bias_q  <= '1;
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            r_en_q <= ramp_d;
          end
        end
        S_BIAS: begin
          state_q <= S_FILL;
          cnt_q   <= '0;
          bfe_q   <= therm(CW'(1));
        end
        S_FILL: begin
          if (cnt_q == CW'(array_size - 1 + drain_cycles)) begin
            state_q  <= S_POOL;
            cnt_q    <= '0;
            mp_arr_q <= '1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            bfe_q <= ramp_d;
          end
        end
        S_POOL: begin
          // cnt_q parks at 2 while waiting; maxpool_done before then is ignored
          if (cnt_q == '0) begin
            mp_fill_q <= '1;
            cnt_q     <= CW'(1);
          end else if (cnt_q == CW'(1)) begin
            mp_rd_q <= '1;
            cnt_q   <= CW'(2);
          end else if (maxpool_done_i) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            r_en_q    <= '0;
            bias_q    <= '0;
            bfe_q     <= '0;
            mp_arr_q  <= '0;
            mp_fill_q <= '0;
            mp_rd_q   <= '0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CNN_SEQ_TIMEOUT_EN
  logic [CW-1:0] wd_q;
  logic          error_q;
  logic          wd_run_d;

  assign wd_run_d  = ((state_q == S_WLOAD) && !w_done_i) ||
                     ((state_q == S_POOL) && (cnt_q == CW'(2)) && !maxpool_done_i);
  assign wd_fire_d = wd_run_d && !abort_i && (wd_q == CW'(timeout_cycles - 1));

  always_ff @(posedge s_clk_i) begin
    if (reset_i) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q <= (wd_run_d && !wd_fire_d) ? wd_q + CW'(1) : '0;
      if (accept_d)       error_q <= 1'b0;
      else if (wd_fire_d) error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign wd_fire_d = 1'b0;
  assign error_o   = 1'b0;
`endif

  assign busy_o                = busy_q;
  assign done_o                = done_q;
  assign clear_n_o             = clear_n_q;
  assign relu_clear_o          = {array_size{clear_n_q}};
  assign buffer_fill_reset_o   = {array_size{clear_n_q}};
  assign weight_write_enable_o = we_q;
  assign r_en_o                = r_en_q;
  assign bias_enable_o         = bias_q;
  assign buffer_fill_enable_o  = bfe_q;
  assign maxpool_arr_enable_o  = mp_arr_q;
  assign maxpool_fill_enable_o = mp_fill_q;
  assign maxpool_arr_r_en_o    = mp_rd_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: timeline model of a pass (event times + offsets) checked every cycle.
// Watchdog scenarios are included when CNN_SEQ_TIMEOUT_EN is defined.
module tb_cnn_layer_sequencer;
  localparam int N = 9;
  localparam int C = 4;
  localparam int D = 9;
`ifdef CNN_SEQ_TIMEOUT_EN
  localparam int TO = 16;
  localparam bit WD_EN = 1'b1;
`else
  localparam int TO = 1024;
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, w_done = 1'b0, mpd = 1'b0;
  logic [15:0] slen = '0;
  logic busy, done, error, clear_n, we;
  logic [N-1:0] relu_clear, bfr, r_en, bias, bfe, mp_arr, mp_fill, mp_rd;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .array_size(N), .clear_cycles(C), .drain_cycles(D), .timeout_cycles(TO)
  ) dut (
    .s_clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .stream_len_i(slen), .w_done_i(w_done), .maxpool_done_i(mpd),
    .busy_o(busy), .done_o(done), .error_o(error), .clear_n_o(clear_n),
    .relu_clear_o(relu_clear), .buffer_fill_reset_o(bfr),
    .weight_write_enable_o(we), .r_en_o(r_en), .bias_enable_o(bias),
    .buffer_fill_enable_o(bfe), .maxpool_arr_enable_o(mp_arr),
    .maxpool_fill_enable_o(mp_fill), .maxpool_arr_r_en_o(mp_rd)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int wdelay = 0, pdelay = 0;

  // Model: a pass is a timeline measured in cycles since acceptance (t=0 first busy cycle).
  // tf = first FEED cycle (-1 until w_done seen), td = DONE cycle (-1 until maxpool_done seen).
  bit m_active = 0, m_err = 0, m_post_rst = 0, m_valid = 0, m_fire = 0, live = 0;
  int m_t = 0, m_tf = -1, m_td = -1, m_len = 0, tp = 0, tbias = 0, tfill = 0;
  logic e_busy, e_done, e_err, e_clr, e_we;
  logic [N-1:0] e_ren, e_bias, e_bfe, e_arr, e_mfill, e_mrd;

  function automatic logic [N-1:0] therm(input int n);
    logic [N-1:0] v;
    if (n <= 0) v = '0;
    else if (n >= N) v = '1;
    else v = N'((1 << n) - 1);
    return v;
  endfunction

  function automatic int pool_start();
    return m_tf + N + m_len + 1 + N + D;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_valid = 1; m_active = 0; m_post_rst = 1; m_err = 0; m_tf = -1; m_td = -1; m_t = 0;
    end else begin
      m_post_rst = 0;
      if (m_active) begin
        m_fire = 0;
        tp = (m_tf >= 0) ? pool_start() : 0;
        if (WD_EN && m_td < 0) begin
          if (m_tf < 0 && m_t >= C && !w_done && (m_t - C + 1 >= TO)) m_fire = 1;
          if (m_tf >= 0 && m_t >= tp + 2 && !mpd && (m_t - tp - 1 >= TO)) m_fire = 1;
        end
        if (abort) m_active = 0;
        else if (m_fire) begin m_active = 0; m_err = 1; end
        else if (m_td >= 0) m_active = 0;
        else begin
          if (m_tf < 0 && m_t >= C && w_done) m_tf = m_t + 1;
          else if (m_tf >= 0 && m_t >= tp + 2 && mpd) m_td = m_t + 1;
          m_t++;
        end
      end else if (start && !abort) begin
        m_active = 1; m_t = 0; m_tf = -1; m_td = -1; m_len = int'(slen); m_err = 0;
      end
    end
    e_busy = m_active;
    e_done = m_active && m_td >= 0 && m_t == m_td;
    e_err  = m_err;
    e_clr  = !m_post_rst && !(m_active && m_t < C);
    live   = m_active && m_td < 0;
    e_we   = live && m_t >= C && m_tf < 0;
    e_ren = '0; e_bias = '0; e_bfe = '0; e_arr = '0; e_mfill = '0; e_mrd = '0;
    if (live && m_tf >= 0) begin
      tbias = m_tf + N + m_len;
      tfill = tbias + 1;
      tp    = tfill + N + D;
      e_ren   = therm(m_t - m_tf + 1);
      e_bias  = (m_t >= tbias) ? '1 : '0;
      e_bfe   = (m_t >= tfill) ? therm(m_t - tfill + 1) : '0;
      e_arr   = (m_t >= tp) ? '1 : '0;
      e_mfill = (m_t >= tp + 1) ? '1 : '0;
      e_mrd   = (m_t >= tp + 2) ? '1 : '0;
    end
  end

  // datapath responders: delay-driven inside their wait windows, random noise elsewhere
  always @(negedge clk) begin
    if (m_active && m_td < 0 && m_tf < 0 && m_t >= C)
      w_done = (wdelay >= 0) && (m_t - C >= wdelay);
    else
      w_done = 1'($urandom_range(0, 1));
    if (m_active && m_td < 0 && m_tf >= 0 && m_t >= pool_start())
      mpd = (pdelay >= 0) && (m_t - pool_start() >= pdelay);
    else
      mpd = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", N'(busy), N'(e_busy));
      chk("done", N'(done), N'(e_done));
      chk("error", N'(error), N'(e_err));
      chk("clear_n", N'(clear_n), N'(e_clr));
      chk("relu_clear", relu_clear, {N{e_clr}});
      chk("buffer_fill_reset", bfr, {N{e_clr}});
      chk("weight_write_enable", N'(we), N'(e_we));
      chk("r_en", r_en, e_ren);
      chk("bias_enable", bias, e_bias);
      chk("buffer_fill_enable", bfe, e_bfe);
      chk("maxpool_arr_enable", mp_arr, e_arr);
      chk("maxpool_fill_enable", mp_fill, e_mfill);
      chk("maxpool_arr_r_en", mp_rd, e_mrd);
    end
  end

  task automatic run_pass(input int len, input int wd, input int pd, input int abort_at,
                          input int start_at, input bit noise, input int budget,
                          output int busy_n, output int done_n);
    int k;
    wdelay = wd; pdelay = pd;
    @(negedge clk); start = 1'b1; abort = 1'b0; slen = 16'(len);
    @(negedge clk); start = 1'b0;
    busy_n = 0; done_n = 0; k = 0;
    while (k < budget) begin
      busy_n += int'(busy);
      done_n += int'(done);
      if (!m_active) break;
      abort = (k == abort_at);
      start = (k == start_at) || (noise && $urandom_range(0, 7) == 0);
      if (noise) slen = 16'($urandom_range(0, 65535));
      @(negedge clk); k++;
    end
    abort = 1'b0; start = 1'b0;
    if (k >= budget) chk_int("pass_budget_expired", k, -1);
  endtask

  initial begin
    int bn, dn, len, wd, pd, ab, expb;
    repeat (3) @(negedge clk);
    chk_int("reset_clear_n", int'(clear_n), 0);
    reset = 1'b0;
    @(negedge clk);
    chk_int("idle_clear_n", int'(clear_n), 1);
    chk_int("idle_busy", int'(busy), 0);

    // nominal: 4 clear + 6 wload + 12 feed + 1 bias + 18 fill + 11 pool + 1 done
    run_pass(3, 5, 10, -1, -1, 1'b0, 2000, bn, dn);
    chk_int("t2_busy_cycles", bn, 53);
    chk_int("t2_done_pulses", dn, 1);

    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk_int("t6_start_abort_busy", int'(busy), 0);

    // stream_len 0, w_done on entry, maxpool_done early: 4+1+9+1+18+3+1
    run_pass(0, 0, 0, -1, -1, 1'b0, 2000, bn, dn);
    chk_int("t3_busy_cycles", bn, 37);
    chk_int("t3_done_pulses", dn, 1);

    // start in FILL (t=20) ignored, abort in POOL cycle1 (t=36)
    run_pass(2, 0, 50, 36, 20, 1'b0, 2000, bn, dn);
    chk_int("t4_busy_cycles", bn, 37);
    chk_int("t4_done_pulses", dn, 0);

    wdelay = 0;
    @(negedge clk); start = 1'b1; slen = 16'd5;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_int("t1_reset_busy", int'(busy), 0);
    chk_int("t1_reset_r_en", int'(r_en), 0);
    chk_int("t1_reset_clear_n", int'(clear_n), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk_int("t1_after_clear_n", int'(clear_n), 1);
    chk_int("t1_after_busy", int'(busy), 0);

    run_pass(150, 1, 4, -1, -1, 1'b1, 3000, bn, dn);
    chk_int("long_busy_cycles", bn, C + 2 + N + 150 + 1 + N + D + 5 + 1);

    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(0, 20);
      wd  = $urandom_range(0, 6);
      pd  = $urandom_range(0, 12);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : -1;
      expb = C + (wd + 1) + (N + len) + 1 + (N + D) + ((pd > 2) ? pd : 2) + 1 + 1;
      run_pass(len, wd, pd, ab, -1, 1'b1, 3000, bn, dn);
      if (ab >= 0 && ab < expb - 1) begin
        chk_int("rand_abort_busy", bn, ab + 1);
        chk_int("rand_abort_done", dn, 0);
      end else begin
        chk_int("rand_busy_cycles", bn, expb);
        chk_int("rand_done_pulses", dn, 1);
      end
    end

`ifdef CNN_SEQ_TIMEOUT_EN
    run_pass(1, -1, 5, -1, -1, 1'b0, 500, bn, dn);
    chk_int("t5_busy_cycles", bn, 20);
    chk_int("t5_done_pulses", dn, 0);
    chk_int("t5_error_set", int'(error), 1);
    run_pass(1, 2, 3, -1, -1, 1'b0, 500, bn, dn);
    chk_int("t5_restart_busy", bn, 41);
    chk_int("t5_restart_done", dn, 1);
    chk_int("t5_error_cleared", int'(error), 0);
    run_pass(0, 0, -1, -1, -1, 1'b0, 500, bn, dn);
    chk_int("pool_wd_busy", bn, 51);
    chk_int("pool_wd_error", int'(error), 1);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
